// File: rtl/multi_ser_host.sv
// Host front end for a bit-serial multiplier: serializes two W-bit operands LSB-first
// and deserializes the 2W-bit product. Optional MULTI_SER_SIGNED_EN: sign-extend padding beats.
module multi_ser_host #(
  parameter int W       = 4,
  parameter int OUT_DLY = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           ser_valid,
  output logic           ser_a,
  output logic           ser_b,
  input  logic           ser_o,
  output logic           prod_valid,
  input  logic           prod_ready,
  output logic [2*W-1:0] prod,
  output logic           busy
);

  localparam int PW = 2 * W;
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [CW-1:0] LAST = CW'(PW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0] r_beat;
  logic [CW-1:0] r_cap_cnt;
  logic [PW-2:0] r_a_sh;
  logic [PW-2:0] r_b_sh;
  logic [PW-1:0] r_prod;
  logic          r_ser_valid;
  logic          r_ser_a;
  logic          r_ser_b;

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_ext;
  logic          w_accept;
  logic          w_cap_en;
  logic          w_cap_last;

`ifdef MULTI_SER_SIGNED_EN
  assign w_a_ext = {{W{in_a[W-1]}}, in_a};
  assign w_b_ext = {{W{in_b[W-1]}}, in_b};
`else
  assign w_a_ext = {{W{1'b0}}, in_a};
  assign w_b_ext = {{W{1'b0}}, in_b};
`endif

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_cap_last = w_cap_en && (r_cap_cnt == LAST);

  // Capture strobe: the beat's ser_valid delayed by OUT_DLY cycles.
  genvar gi;
  generate
    if (OUT_DLY == 0) begin : g_nodly
      assign w_cap_en = r_ser_valid;
    end else begin : g_dly
      logic r_vdly [OUT_DLY];
      for (gi = 0; gi < OUT_DLY; gi++) begin : g_tap
        if (gi == 0) begin : g_first
          always_ff @(posedge CLK or posedge RST) begin
            if (RST) r_vdly[gi] <= 1'b0;
            else     r_vdly[gi] <= r_ser_valid;
          end
        end else begin : g_rest
          always_ff @(posedge CLK or posedge RST) begin
            if (RST) r_vdly[gi] <= 1'b0;
            else     r_vdly[gi] <= r_vdly[gi-1];
          end
        end
      end
      assign w_cap_en = r_vdly[OUT_DLY-1];
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_SEND;
      S_SEND:  if (r_beat == LAST) w_state_next = (OUT_DLY == 0) ? S_HOLD : S_DRAIN;
      S_DRAIN: if (w_cap_last) w_state_next = S_HOLD;
      S_HOLD:  if (prod_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == S_IDLE);
    busy       = (r_state != S_IDLE);
    prod_valid = (r_state == S_HOLD);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ser_valid <= 1'b0;
      r_ser_a     <= 1'b0;
      r_ser_b     <= 1'b0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_beat      <= '0;
      r_cap_cnt   <= '0;
      r_prod      <= '0;
    end else begin
      if (w_accept) begin
        // Beat 0 is registered at acceptance; the rest wait in the shifters.
        r_ser_valid <= 1'b1;
        r_ser_a     <= w_a_ext[0];
        r_ser_b     <= w_b_ext[0];
        r_a_sh      <= w_a_ext[PW-1:1];
        r_b_sh      <= w_b_ext[PW-1:1];
        r_beat      <= '0;
        r_cap_cnt   <= '0;
      end else if (r_state == S_SEND) begin
        if (r_beat == LAST) begin
          r_ser_valid <= 1'b0;
          r_ser_a     <= 1'b0;
          r_ser_b     <= 1'b0;
        end else begin
          r_ser_a <= r_a_sh[0];
          r_ser_b <= r_b_sh[0];
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_beat  <= r_beat + CW'(1);
        end
      end
      if (w_cap_en) begin
        r_prod    <= {ser_o, r_prod[PW-1:1]};
        r_cap_cnt <= r_cap_cnt + CW'(1);
      end
    end
  end

  assign ser_valid = r_ser_valid;
  assign ser_a     = r_ser_a;
  assign ser_b     = r_ser_b;
  assign prod      = r_prod;

endmodule

// File: tb/tb_multi_ser_host.sv
// Bench for multi_ser_host: three instances (OUT_DLY 1, 0, 3), each fed by a
// behavioural bit-serial multiplier model on its ser_* pins.
module tb_multi_ser_host;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid   [3];
  logic       in_ready   [3];
  logic [3:0] in_a       [3];
  logic [3:0] in_b       [3];
  logic       ser_valid  [3];
  logic       ser_a      [3];
  logic       ser_b      [3];
  logic       ser_o      [3];
  logic       prod_valid [3];
  logic       prod_ready [3];
  logic [7:0] prod       [3];
  logic       busy       [3];

  int n_total = 0;
  int n_bad   = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_u
      localparam int DLY = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);

      multi_ser_host #(.W(4), .OUT_DLY(DLY)) u_dut (
        .CLK       (clk),
        .RST       (rst),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .in_a      (in_a[gi]),
        .in_b      (in_b[gi]),
        .ser_valid (ser_valid[gi]),
        .ser_a     (ser_a[gi]),
        .ser_b     (ser_b[gi]),
        .ser_o     (ser_o[gi]),
        .prod_valid(prod_valid[gi]),
        .prod_ready(prod_ready[gi]),
        .prod      (prod[gi]),
        .busy      (busy[gi])
      );

      // Serial multiplier: product bit i depends only on operand bits 0..i.
      logic [7:0]  ma, mb, cur_a, cur_b;
      logic [2:0]  mi;
      logic [15:0] mp;
      logic        pbit;
      logic [7:0]  dl;

      always_comb begin
        cur_a = ma | ({7'b0, ser_a[gi]} << mi);
        cur_b = mb | ({7'b0, ser_b[gi]} << mi);
        mp    = {8'b0, cur_a} * {8'b0, cur_b};
        pbit  = mp[mi];
      end

      always @(posedge clk or posedge rst) begin
        if (rst) begin
          ma <= '0; mb <= '0; mi <= '0; dl <= '0;
        end else begin
          dl <= {dl[6:0], pbit};
          if (ser_valid[gi]) begin
            mi <= mi + 3'd1;
            if (mi == 3'd7) begin
              ma <= '0; mb <= '0;
            end else begin
              ma <= cur_a; mb <= cur_b;
            end
          end
        end
      end

      if (DLY == 0) begin : g_o0
        assign ser_o[gi] = pbit;
      end else begin : g_on
        assign ser_o[gi] = dl[DLY-1];
      end
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic run_job(input int u, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] sa, input logic [7:0] sb,
                         input logic [7:0] want_p, input int dly);
    int cnt;
    @(negedge clk);
    in_valid[u] = 1'b1; in_a[u] = a; in_b[u] = b;
    @(negedge clk);
    in_valid[u] = 1'b0;
    chk("in_ready_drop", in_ready[u], 0);
    chk("busy_high", busy[u], 1);
    for (int k = 0; k < 8; k++) begin
      chk("beat_valid", ser_valid[u], 1);
      chk("beat_a", ser_a[u], sa[k]);
      chk("beat_b", ser_b[u], sb[k]);
      @(negedge clk);
    end
    chk("ser_valid_off", ser_valid[u], 0);
    cnt = 9;
    while (!prod_valid[u] && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", cnt, 9 + dly);
    chk("prod", prod[u], want_p);
    $display("job inst=%0d a=%0d b=%0d prod=%0h latency=%0d", u, a, b, prod[u], cnt);
  endtask

  task automatic release_prod(input int u);
    @(negedge clk);
    prod_ready[u] = 1'b1;
    @(negedge clk);
    prod_ready[u] = 1'b0;
    chk("idle_ready", in_ready[u], 1);
    chk("prod_valid_clear", prod_valid[u], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0; prod_ready[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_ser_valid", ser_valid[0], 0);
    chk("rst_prod_valid", prod_valid[0], 0);
    chk("rst_prod", prod[0], 0);
    rst = 1'b0;

    // Reset on beat 2 of a 15*15 job.
    @(negedge clk);
    in_valid[0] = 1'b1; in_a[0] = 4'hF; in_b[0] = 4'hF;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", ser_valid[0], 1);
    rst = 1'b1;
    #1;
    chk("rst_async_sv", ser_valid[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready[0], 1);
    chk("post_rst_pv", prod_valid[0], 0);
    chk("post_rst_prod", prod[0], 0);
    $display("reset mid-send done");

    run_job(0, 4'd15, 4'd15, 8'b0000_1111, 8'b0000_1111, 8'd225, 1);

    // Backpressure: product holds, new operands are ignored.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1; in_a[0] = 4'd1; in_b[0] = 4'd1;
      chk("bp_prod", prod[0], 225);
      chk("bp_in_ready", in_ready[0], 0);
      chk("bp_prod_valid", prod_valid[0], 1);
    end
    in_valid[0] = 1'b0;
    release_prod(0);
    @(negedge clk);
    chk("bp_no_restart", busy[0], 0);
    chk("bp_prod_kept", prod[0], 225);
    $display("backpressure done");

    run_job(0, 4'd0, 4'd9, 8'b0000_0000, 8'b0000_1001, 8'd0, 1);
    release_prod(0);

    run_job(1, 4'd6, 4'd7, 8'b0000_0110, 8'b0000_0111, 8'd42, 0);
    release_prod(1);
    run_job(2, 4'd6, 4'd7, 8'b0000_0110, 8'b0000_0111, 8'd42, 3);
    release_prod(2);

`ifdef MULTI_SER_SIGNED_EN
    run_job(0, 4'b1110, 4'b0011, 8'b1111_1110, 8'b0000_0011, 8'hFA, 1);
`else
    run_job(0, 4'b1110, 4'b0011, 8'b0000_1110, 8'b0000_0011, 8'd42, 1);
`endif
    release_prod(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_ser_host.md
Name: multi_ser_host

Overview:
- Host-side front end for the bit-serial multiplier `multi_top`, whose interface is CLK, RST, VALID, serial A, serial B and serial O.
- Accepts two parallel W-bit operands over a valid/ready handshake.
- Drives them LSB-first as serial A/B bit streams with VALID asserted.
- Deserializes the returned O stream into a parallel 2W-bit product and presents it over a second valid/ready handshake.

Parameters:
- W, 4: operand width in bits. Product width is 2W.
- OUT_DLY, 1: number of cycles from a serial beat on A/B/VALID to the corresponding product bit on O. Range 0..7.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- in_a  input  W  multiplicand.
- in_b  input  W  multiplier.
- ser_valid  output  1  to multi_top VALID.
- ser_a  output  1  to multi_top A.
- ser_b  output  1  to multi_top B.
- ser_o  input  1  from multi_top O.
- prod_valid  output  1  product available.
- prod_ready  input  1  consumer accepts product.
- prod  output  2W  product, bit i = i-th received O bit.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, any state): FSM enters IDLE.
  - Outputs: ser_valid=0, ser_a=0, ser_b=0, prod_valid=0, prod=0, busy=0, in_ready=1.
  - All counters and shift registers clear.
- All serial outputs are registered. No combinational path from in_* to ser_*.
- FSM states: IDLE, SEND, DRAIN, HOLD.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: latch in_a/in_b into shift registers, clear beat counter, go to SEND.
  - in_ready drops in the same cycle as the state change.
- SEND: lasts exactly 2W cycles. ser_valid=1 throughout.
  - Beats 0..W-1: ser_a=a[k], ser_b=b[k].
  - Beats W..2W-1: padding. Zeros by default; see Optional Feature.
  - First beat appears the cycle after acceptance.
- Capture: the i-th O bit is sampled OUT_DLY cycles after beat i was driven, for i=0..2W-1.
  - With OUT_DLY=0, O is sampled in the same cycle as its beat.
  - Capture shifts into prod from the MSB end, so after 2W samples bit 0 is the first sample.
- DRAIN: entered after the last SEND beat when OUT_DLY>0.
  - ser_valid=0, ser_a=0, ser_b=0.
  - Remains until all 2W bits are captured.
  - With OUT_DLY=0, SEND goes directly to HOLD.
- HOLD:
  - prod_valid=1, prod stable.
  - Leaves on a rising edge with prod_ready=1 and returns to IDLE; prod_valid clears.
  - prod keeps its last value until the next capture begins.
- Latency, in_valid handshake to prod_valid rising: 2W+OUT_DLY+1 cycles (W=4, OUT_DLY=1: 10 cycles).
- Back-to-back operation: no acceptance in HOLD; no overlap of jobs. Minimum issue interval is 2W+OUT_DLY+2 cycles with prod_ready tied high.
- in_valid asserted outside IDLE is ignored. Operands are not buffered.
- prod_ready outside HOLD is ignored.
- RST asserted mid-SEND: ser_valid drops immediately (asynchronous) and the partial product is discarded.

Optional Feature:
- Macro: MULTI_SER_SIGNED_EN.
- Defined:
  - Padding beats W..2W-1 drive ser_a=a[W-1] and ser_b=b[W-1], i.e. sign extension for two's-complement operands.
  - prod is treated as a signed 2W-bit result; capture is unchanged.
- Undefined: padding beats drive 0 (unsigned operation).

Test Plan:
- Reset mid-SEND: W=4, start a=4'b1111, b=4'b1111, assert RST on beat 2.
  - ser_valid=0 within the same cycle.
  - in_ready=1 and prod_valid=0 after release.
  - A new job then completes normally.
- Basic unsigned: W=4, OUT_DLY=1, behavioural serial-multiplier model on ser_*, a=15, b=15.
  - ser_a/ser_b = 1,1,1,1,0,0,0,0 with ser_valid high for 8 cycles.
  - prod=8'd225, prod_valid rising 10 cycles after handshake.
- Backpressure: hold prod_ready=0 for 5 cycles after prod_valid.
  - prod stays 225, in_ready stays 0, and a new in_valid is ignored.
  - Release prod_ready: IDLE follows the next cycle.
- Zero operands: a=0, b=9 -> prod=0, full 8-beat sequence still emitted.
- OUT_DLY=0 and OUT_DLY=3: a=6, b=7 -> prod=42 in both.
  - DRAIN length is 0 and 3 cycles respectively; latency is 9 and 12 cycles.
- With MULTI_SER_SIGNED_EN defined, a=4'b1110 (-2), b=4'b0011 (3):
  - Padding beats drive ser_a=1, ser_b=0.
  - prod=8'hFA (-6).
  - Without the macro: prod=8'd42 (14*3).
